// File: rtl/briey_program_loader.sv
// Copies a program image from host memory into the core RAM, one 64-byte line at a time.
// Each line is read over AXI into a line buffer, then written to the RAM load port.
module briey_program_loader #(
    parameter int RAM_AW = 15,
    parameter int LEN_W  = 10,
    parameter int AXI_ID = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [63:0]       src_base,
    input  logic [RAM_AW-1:0] dst_base,
    input  logic [LEN_W-1:0]  num_lines,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              aborted,
    output logic [LEN_W-1:0]  lines_done,
    output logic              arvalid,
    input  logic              arready,
    output logic [63:0]       araddr,
    output logic [11:0]       arid,
    output logic [9:0]        arlen,
    output logic [2:0]        arsize,
    input  logic              rvalid,
    output logic              rready,
    input  logic [511:0]      rdata,
    input  logic [1:0]        rresp,
    output logic              load_en,
    output logic              aw_valid,
    input  logic              aw_ready,
    output logic [RAM_AW-1:0] aw_addr,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [511:0]      w_data,
    output logic [63:0]       w_strb
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_WR
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   n_lines;
    logic               aw_seen;
    logic               w_seen;
    logic               aw_fire;
    logic               w_fire;
    logic               aw_ok;
    logic               w_ok;
    logic [LEN_W-1:0]   ld_next;
    logic               misaligned;

    assign arid    = 12'(AXI_ID);
    assign arlen   = 10'd0;
    assign arsize  = 3'b110;
    assign w_strb  = '1;
    assign busy    = (state != S_IDLE);
    assign load_en = busy;

    assign aw_fire    = aw_valid & aw_ready;
    assign w_fire     = w_valid & w_ready;
    assign aw_ok      = aw_seen | aw_fire;
    assign w_ok       = w_seen | w_fire;
    assign ld_next    = lines_done + LEN_W'(1);
    assign misaligned = (src_base[5:0] != 6'd0) || (dst_base[5:0] != 6'd0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            n_lines    <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            aborted    <= 1'b0;
            lines_done <= '0;
            arvalid    <= 1'b0;
            araddr     <= '0;
            rready     <= 1'b0;
            aw_valid   <= 1'b0;
            aw_addr    <= '0;
            w_valid    <= 1'b0;
            w_data     <= '0;
            aw_seen    <= 1'b0;
            w_seen     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (misaligned) begin
                            error   <= 1'b1;
                            done    <= 1'b0;
                            aborted <= 1'b0;
                        end else if (num_lines == '0) begin
                            done       <= 1'b1;
                            error      <= 1'b0;
                            aborted    <= 1'b0;
                            lines_done <= '0;
                        end else begin
                            araddr     <= src_base;
                            aw_addr    <= dst_base;
                            n_lines    <= num_lines;
                            done       <= 1'b0;
                            error      <= 1'b0;
                            aborted    <= 1'b0;
                            lines_done <= '0;
                            arvalid    <= 1'b1;
                            state      <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    // A handshake in the same cycle as abort wins: the read is committed.
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_R;
                    end else if (abort) begin
                        arvalid <= 1'b0;
                        aborted <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        w_data <= rdata;
                        if (rresp != 2'b00) begin
                            error <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            aw_valid <= 1'b1;
                            w_valid  <= 1'b1;
                            aw_seen  <= 1'b0;
                            w_seen   <= 1'b0;
                            state    <= S_WR;
                        end
                    end
                end
                S_WR: begin
                    if (aw_fire) begin
                        aw_valid <= 1'b0;
                        aw_seen  <= 1'b1;
                    end
                    if (w_fire) begin
                        w_valid <= 1'b0;
                        w_seen  <= 1'b1;
                    end
                    if (aw_ok && w_ok) begin
                        lines_done <= ld_next;
                        if (ld_next == n_lines) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else if (abort) begin
                            aborted <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            araddr  <= araddr + 64'd64;
                            aw_addr <= aw_addr + RAM_AW'(64);
                            arvalid <= 1'b1;
                            state   <= S_AR;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_briey_program_loader.sv
// Directed bench for briey_program_loader with a simple AXI read slave
// and RAM load-port sink whose ready latencies are adjustable.
module tb_briey_program_loader;

    logic         clk;
    logic         rstn;
    logic         start;
    logic         abort;
    logic [63:0]  src_base;
    logic [14:0]  dst_base;
    logic [9:0]   num_lines;
    logic         busy;
    logic         done;
    logic         error;
    logic         aborted;
    logic [9:0]   lines_done;
    logic         arvalid;
    logic         arready;
    logic [63:0]  araddr;
    logic [11:0]  arid;
    logic [9:0]   arlen;
    logic [2:0]   arsize;
    logic         rvalid;
    logic         rready;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         load_en;
    logic         aw_valid;
    logic         aw_ready;
    logic [14:0]  aw_addr;
    logic         w_valid;
    logic         w_ready;
    logic [511:0] w_data;
    logic [63:0]  w_strb;

    int n_chk;
    int n_fail;

    // slave controls
    logic         ar_rdy;
    logic         r_vld;
    logic [63:0]  bad_addr;
    int           aw_lat;
    int           w_lat;
    int           aw_cnt;
    int           w_cnt;
    logic [63:0]  cur_ar;
    int           arv_cnt;

    logic [63:0]  ar_log[$];
    logic [14:0]  aw_log[$];
    logic [511:0] wd_log[$];
    logic [511:0] ad_log[$];

    briey_program_loader dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .num_lines  (num_lines),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .aborted    (aborted),
        .lines_done (lines_done),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .arid       (arid),
        .arlen      (arlen),
        .arsize     (arsize),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .rresp      (rresp),
        .load_en    (load_en),
        .aw_valid   (aw_valid),
        .aw_ready   (aw_ready),
        .aw_addr    (aw_addr),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .w_strb     (w_strb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign arready  = ar_rdy;
    assign rvalid   = r_vld;
    assign rdata    = {8{cur_ar}};
    assign rresp    = (cur_ar == bad_addr) ? 2'b10 : 2'b00;
    assign aw_ready = (aw_cnt >= aw_lat);
    assign w_ready  = (w_cnt >= w_lat);

    always @(posedge clk) begin
        aw_cnt <= aw_valid ? aw_cnt + 1 : 0;
        w_cnt  <= w_valid ? w_cnt + 1 : 0;
        if (rstn) begin
            if (arvalid) arv_cnt <= arv_cnt + 1;
            if (arvalid && arready) begin
                ar_log.push_back(araddr);
                cur_ar <= araddr;
            end
            if (aw_valid && aw_ready) begin
                aw_log.push_back(aw_addr);
                ad_log.push_back(w_data);
            end
            if (w_valid && w_ready) wd_log.push_back(w_data);
        end
    end

    task automatic go(input logic [63:0] s, input logic [14:0] d,
                      input logic [9:0] n, input int restart_at,
                      output int cyc);
        @(negedge clk);
        src_base  = s;
        dst_base  = d;
        num_lines = n;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (busy && cyc < 500) begin
            cyc++;
            if (cyc == restart_at) begin
                start     = 1'b1;
                src_base  = 64'h8000;
                num_lines = 10'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (busy !== 1'b0) begin
            $display("FAIL run_timeout: busy=%0b after %0d cycles, need 0", busy, cyc);
            n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_reset();
        if ({busy, done, error, aborted, arvalid, rready, aw_valid, w_valid, load_en} !== 9'd0) begin
            $display("FAIL reset_ctrl: got %b need 0", {busy, done, error, aborted, arvalid, rready, aw_valid, w_valid, load_en});
            n_fail++;
        end
        n_chk++;
        if (lines_done !== 10'd0 || araddr !== 64'd0 || aw_addr !== 15'd0 || w_data !== 512'd0) begin
            $display("FAIL reset_data: ld=%h ar=%h aw=%h wd0=%h need 0", lines_done, araddr, aw_addr, w_data[63:0]);
            n_fail++;
        end
        n_chk++;
        if (arid !== 12'd0 || arlen !== 10'd0 || arsize !== 3'b110 || w_strb !== {64{1'b1}}) begin
            $display("FAIL reset_const: arid=%h arlen=%h arsize=%b strb=%h", arid, arlen, arsize, w_strb);
            n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_basic_copy();
        int cyc;
        int a0;
        int w0;
        a0 = ar_log.size();
        w0 = aw_log.size();
        go(64'h1000, 15'h0, 10'd3, 0, cyc);
        if (cyc !== 9) begin
            $display("FAIL basic_busy_cycles: got %0d need 9", cyc);
            n_fail++;
        end
        n_chk++;
        if (done !== 1'b1 || error !== 1'b0 || aborted !== 1'b0 || lines_done !== 10'd3) begin
            $display("FAIL basic_status: done=%b err=%b ab=%b ld=%0d need 1 0 0 3", done, error, aborted, lines_done);
            n_fail++;
        end
        n_chk++;
        if (ar_log.size() - a0 !== 3 || aw_log.size() - w0 !== 3) begin
            $display("FAIL basic_counts: ar=%0d aw=%0d need 3 3", ar_log.size() - a0, aw_log.size() - w0);
            n_fail++;
        end else begin
            if (ar_log[a0] !== 64'h1000 || ar_log[a0+1] !== 64'h1040 || ar_log[a0+2] !== 64'h1080) begin
                $display("FAIL basic_araddr: got %h %h %h need 1000 1040 1080", ar_log[a0], ar_log[a0+1], ar_log[a0+2]);
                n_fail++;
            end
            n_chk++;
            if (aw_log[w0] !== 15'h0 || aw_log[w0+1] !== 15'h40 || aw_log[w0+2] !== 15'h80) begin
                $display("FAIL basic_awaddr: got %h %h %h need 0 40 80", aw_log[w0], aw_log[w0+1], aw_log[w0+2]);
                n_fail++;
            end
            n_chk++;
            if (wd_log[w0+2] !== {8{64'h1080}} || wd_log[w0] !== {8{64'h1000}}) begin
                $display("FAIL basic_wdata: got %h %h need 1000 1080", wd_log[w0][63:0], wd_log[w0+2][63:0]);
                n_fail++;
            end
            n_chk++;
        end
        n_chk++;
    endtask

    task automatic test_abort_idle();
        @(negedge clk);
        abort = 1'b1;
        repeat (3) @(negedge clk);
        if (aborted !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
            $display("FAIL abort_idle: ab=%b busy=%b done=%b need 0 0 1", aborted, busy, done);
            n_fail++;
        end
        n_chk++;
        abort = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc;
        int wf;
        int w0;
        w0     = aw_log.size();
        aw_lat = 5;
        w_lat  = 2;
        @(negedge clk);
        src_base  = 64'h5000;
        dst_base  = 15'h100;
        num_lines = 10'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        wf    = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (aw_valid && !w_valid) begin
                wf++;
                if (lines_done !== 10'd0) begin
                    $display("FAIL bp_early_advance: ld=%0d need 0", lines_done);
                    n_fail++;
                end
                n_chk++;
            end
            @(negedge clk);
        end
        if (wf !== 3 || cyc !== 8) begin
            $display("FAIL bp_timing: wfirst=%0d cyc=%0d need 3 8", wf, cyc);
            n_fail++;
        end
        n_chk++;
        if (done !== 1'b1 || lines_done !== 10'd1 || aw_log.size() - w0 !== 1) begin
            $display("FAIL bp_status: done=%b ld=%0d wr=%0d need 1 1 1", done, lines_done, aw_log.size() - w0);
            n_fail++;
        end else if (aw_log[w0] !== 15'h100 || wd_log[w0] !== {8{64'h5000}} || ad_log[w0] !== {8{64'h5000}}) begin
            $display("FAIL bp_data: aw=%h wd=%h ad=%h need 100 5000 5000", aw_log[w0], wd_log[w0][63:0], ad_log[w0][63:0]);
            n_fail++;
        end
        n_chk++;
        aw_lat = 0;
        w_lat  = 0;
    endtask

    task automatic test_error_path();
        int cyc;
        int w0;
        w0       = aw_log.size();
        bad_addr = 64'h2040;
        go(64'h2000, 15'h200, 10'd4, 0, cyc);
        if (error !== 1'b1 || done !== 1'b0 || aborted !== 1'b0 || lines_done !== 10'd1) begin
            $display("FAIL err_status: err=%b done=%b ab=%b ld=%0d need 1 0 0 1", error, done, aborted, lines_done);
            n_fail++;
        end
        n_chk++;
        if (aw_log.size() - w0 !== 1 || cyc !== 5) begin
            $display("FAIL err_writes: wr=%0d cyc=%0d need 1 5", aw_log.size() - w0, cyc);
            n_fail++;
        end
        n_chk++;
        bad_addr = '1;
        go(64'h3000, 15'h0, 10'd1, 0, cyc);
        if (error !== 1'b0 || done !== 1'b1 || lines_done !== 10'd1) begin
            $display("FAIL err_clear: err=%b done=%b ld=%0d need 0 1 1", error, done, lines_done);
            n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_boundaries();
        int cyc;
        int w0;
        int a0;
        w0 = aw_log.size();
        go(64'h0, 15'h7FC0, 10'd2, 0, cyc);
        if (aw_log.size() - w0 !== 2) begin
            $display("FAIL wrap_count: wr=%0d need 2", aw_log.size() - w0);
            n_fail++;
        end else if (aw_log[w0] !== 15'h7FC0 || aw_log[w0+1] !== 15'h0000) begin
            $display("FAIL wrap_addr: got %h %h need 7fc0 0000", aw_log[w0], aw_log[w0+1]);
            n_fail++;
        end
        n_chk++;
        a0 = arv_cnt;
        go(64'h1004, 15'h0, 10'd2, 0, cyc);
        repeat (2) @(negedge clk);
        if (error !== 1'b1 || done !== 1'b0 || arv_cnt !== a0 || cyc !== 0) begin
            $display("FAIL misaligned: err=%b done=%b arv=%0d cyc=%0d need 1 0 0 0", error, done, arv_cnt - a0, cyc);
            n_fail++;
        end
        n_chk++;
        go(64'h1000, 15'h0, 10'd0, 0, cyc);
        repeat (2) @(negedge clk);
        if (done !== 1'b1 || error !== 1'b0 || aborted !== 1'b0 || arv_cnt !== a0 || busy !== 1'b0) begin
            $display("FAIL zero_lines: done=%b err=%b ab=%b arv=%0d busy=%b need 1 0 0 0 0", done, error, aborted, arv_cnt - a0, busy);
            n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_abort();
        int cyc;
        int a0;
        int w0;
        a0     = ar_log.size();
        ar_rdy = 1'b0;
        @(negedge clk);
        src_base  = 64'h7000;
        dst_base  = 15'h300;
        num_lines = 10'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        if (busy !== 1'b0 || aborted !== 1'b1 || arvalid !== 1'b0 || lines_done !== 10'd0 || ar_log.size() !== a0) begin
            $display("FAIL abort_ar: busy=%b ab=%b arv=%b ld=%0d ar=%0d need 0 1 0 0 0", busy, aborted, arvalid, lines_done, ar_log.size() - a0);
            n_fail++;
        end
        n_chk++;
        abort  = 1'b0;
        ar_rdy = 1'b1;
        r_vld  = 1'b0;
        w0     = aw_log.size();
        @(negedge clk);
        src_base  = 64'h9000;
        dst_base  = 15'h400;
        num_lines = 10'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!rready && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        abort = 1'b1;
        repeat (2) @(negedge clk);
        if (busy !== 1'b1 || rready !== 1'b1) begin
            $display("FAIL abort_r_hold: busy=%b rready=%b need 1 1", busy, rready);
            n_fail++;
        end
        n_chk++;
        r_vld = 1'b1;
        cyc   = 0;
        while (busy && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        if (aborted !== 1'b1 || done !== 1'b0 || lines_done !== 10'd1 || aw_log.size() - w0 !== 1 || busy !== 1'b0) begin
            $display("FAIL abort_r: ab=%b done=%b ld=%0d wr=%0d busy=%b need 1 0 1 1 0", aborted, done, lines_done, aw_log.size() - w0, busy);
            n_fail++;
        end
        n_chk++;
        abort = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int a0;
        a0 = ar_log.size();
        go(64'h4000, 15'h600, 10'd2, 3, cyc);
        if (done !== 1'b1 || aborted !== 1'b0 || lines_done !== 10'd2 || cyc !== 6) begin
            $display("FAIL b2b_status: done=%b ab=%b ld=%0d cyc=%0d need 1 0 2 6", done, aborted, lines_done, cyc);
            n_fail++;
        end
        n_chk++;
        if (ar_log.size() - a0 !== 2) begin
            $display("FAIL b2b_ignore_start: ar=%0d need 2", ar_log.size() - a0);
            n_fail++;
        end else if (ar_log[a0] !== 64'h4000 || ar_log[a0+1] !== 64'h4040) begin
            $display("FAIL b2b_araddr: got %h %h need 4000 4040", ar_log[a0], ar_log[a0+1]);
            n_fail++;
        end
        n_chk++;
        go(64'hA000, 15'h0, 10'd1, 0, cyc);
        if (done !== 1'b1 || lines_done !== 10'd1 || ar_log[ar_log.size()-1] !== 64'hA000) begin
            $display("FAIL b2b_second: done=%b ld=%0d ar=%h need 1 1 a000", done, lines_done, ar_log[ar_log.size()-1]);
            n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_reset_midrun();
        int cyc;
        aw_lat = 20;
        @(negedge clk);
        src_base  = 64'h6000;
        dst_base  = 15'h200;
        num_lines = 10'd2;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!aw_valid && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        if (aw_valid !== 1'b1) begin
            $display("FAIL rst_reach_wr: aw_valid=%b need 1", aw_valid);
            n_fail++;
        end
        n_chk++;
        rstn = 1'b0;
        @(negedge clk);
        if ({busy, done, error, aborted, arvalid, rready, aw_valid, w_valid, load_en} !== 9'd0) begin
            $display("FAIL rst_mid_ctrl: got %b need 0", {busy, done, error, aborted, arvalid, rready, aw_valid, w_valid, load_en});
            n_fail++;
        end
        n_chk++;
        if (lines_done !== 10'd0 || araddr !== 64'd0 || aw_addr !== 15'd0 || w_data !== 512'd0) begin
            $display("FAIL rst_mid_data: ld=%h ar=%h aw=%h wd0=%h need 0", lines_done, araddr, aw_addr, w_data[63:0]);
            n_fail++;
        end
        n_chk++;
        rstn   = 1'b1;
        aw_lat = 0;
        @(negedge clk);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        src_base  = '0;
        dst_base  = '0;
        num_lines = '0;
        ar_rdy    = 1'b1;
        r_vld     = 1'b1;
        bad_addr  = '1;
        aw_lat    = 0;
        w_lat     = 0;
        aw_cnt    = 0;
        w_cnt     = 0;
        cur_ar    = '0;
        arv_cnt   = 0;
        repeat (3) @(negedge clk);
        test_reset();
        rstn = 1'b1;
        @(negedge clk);
        test_basic_copy();
        test_abort_idle();
        test_backpressure();
        test_error_path();
        test_boundaries();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
